// File: rtl/wallace_mac_pkg.sv
// Shared types and widths for the product accumulator datapath.
// No logic; constants and state encoding only.
// No flow control; consumers define their own handshakes.
package wallace_mac_pkg;
   localparam int PROD_W    = 16;
   localparam int ACC_W_DEF = 24;
   localparam int LEN_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;
endpackage

// File: rtl/wallace_acc_adder.sv
// Accumulator adder: ACC_W-bit sum of the running total and a zero-extended product.
// Latency 0 (purely combinational).
// No backpressure; the parent decides when the result is captured.
module wallace_acc_adder
   import wallace_mac_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic [ACC_W-1:0]  i_acc,
   input  logic [PROD_W-1:0] i_addend,
   output logic [ACC_W-1:0]  o_sum,
   output logic              o_carry
);
   logic [ACC_W:0] w_full;

   assign w_full             = {1'b0, i_acc} + (ACC_W+1)'(i_addend);
   assign {o_carry, o_sum}   = w_full;
endmodule

// File: rtl/wallace_product_accumulator.sv
// Sums blocks of L unsigned products; WALLACE_ACC_SATURATE_EN clamps on overflow instead of wrapping.
// Latency: out_valid rises the cycle after the L-th accept; one block per L+1 cycles.
// Backpressure: result is held and in_ready stays low until out_ready takes it.
module wallace_product_accumulator
   import wallace_mac_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_product,
   input  logic [LEN_W-1:0]  cfg_len,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_acc,
   output logic              out_ovf
);
   state_t           r_state;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_out_acc;
   logic             r_ovf;
   logic             r_out_ovf;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [LEN_W:0]   r_cnt;
   logic [LEN_W:0]   r_len;

   logic [ACC_W-1:0] w_base;
   logic [ACC_W-1:0] w_sum;
   logic [ACC_W-1:0] w_acc_nxt;
   logic             w_carry;
   logic             w_ovf_nxt;
   logic             w_accept;
   logic             w_done;
   logic [LEN_W:0]   w_len_eff;
   logic [LEN_W:0]   w_cnt_inc;

   // First product of a block adds onto zero, so one adder serves both states.
   assign w_base    = (r_state == IDLE) ? '0 : r_acc;
   assign w_accept  = in_valid && r_in_ready;
   assign w_len_eff = (cfg_len == '0) ? (LEN_W+1)'(1) : {1'b0, cfg_len};
   assign w_cnt_inc = r_cnt + (LEN_W+1)'(1);
   assign w_done    = (r_state == IDLE) ? (w_len_eff == (LEN_W+1)'(1))
                                        : (w_cnt_inc == r_len);
   assign w_ovf_nxt = w_carry || ((r_state != IDLE) && r_ovf);

   wallace_acc_adder #(.ACC_W(ACC_W)) u_adder (
      .i_acc    (w_base),
      .i_addend (in_product),
      .o_sum    (w_sum),
      .o_carry  (w_carry)
   );

`ifdef WALLACE_ACC_SATURATE_EN
   assign w_acc_nxt = w_carry ? '1 : w_sum;
`else
   assign w_acc_nxt = w_sum;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_acc       <= '0;
         r_out_acc   <= '0;
         r_ovf       <= 1'b0;
         r_out_ovf   <= 1'b0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_cnt       <= '0;
         r_len       <= '0;
      end else begin
         case (r_state)
            IDLE, ACCUM: begin
               r_in_ready <= 1'b1;
               if (w_accept) begin
                  r_acc <= w_acc_nxt;
                  r_ovf <= w_ovf_nxt;
                  r_cnt <= (r_state == IDLE) ? (LEN_W+1)'(1) : w_cnt_inc;
                  if (r_state == IDLE) r_len <= w_len_eff;
                  if (w_done) begin
                     r_state     <= HOLD;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_out_acc   <= w_acc_nxt;
                     r_out_ovf   <= w_ovf_nxt;
                  end else begin
                     r_state <= ACCUM;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_acc   = r_out_acc;
   assign out_ovf   = r_out_ovf;
endmodule
